// File: rtl/mips_axi_pkg.sv
// Shared definitions for the MIPS CPU AXI4-Lite memory slave: response codes,
// bus widths, FSM state encodings, the captured-write payload and an
// address range helper.
package mips_axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned RD_CNT_W   = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  // Write request assembled from independently captured AW and W beats.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } wr_req_t;

  // True when any byte-address bit above the word-index field is set.
  function automatic logic addr_out_of_range(input logic [AXI_ADDR_W-1:0] addr,
                                             input int unsigned word_bits);
    logic [AXI_ADDR_W-1:0] mask;
    mask = {AXI_ADDR_W{1'b1}} << (word_bits + 2);
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/mips_axi_mem_slave_if.sv
// AXI4-Lite AR/R/AW/W/B channel bundle between the MIPS CPU (master) and the
// memory slave. Clock and reset travel separately as plain ports.
interface mips_axi_mem_slave_if;

  logic [mips_axi_pkg::AXI_ADDR_W-1:0] axi_s_araddr;
  logic                                axi_s_arvalid;
  logic                                axi_s_arready;
  logic [mips_axi_pkg::AXI_DATA_W-1:0] axi_s_rdata;
  logic [1:0]                          axi_s_rresp;
  logic                                axi_s_rvalid;
  logic                                axi_s_rready;
  logic [mips_axi_pkg::AXI_ADDR_W-1:0] axi_s_awaddr;
  logic                                axi_s_awvalid;
  logic                                axi_s_awready;
  logic [mips_axi_pkg::AXI_DATA_W-1:0] axi_s_wdata;
  logic [mips_axi_pkg::AXI_STRB_W-1:0] axi_s_wstrb;
  logic                                axi_s_wvalid;
  logic                                axi_s_wready;
  logic [1:0]                          axi_s_bresp;
  logic                                axi_s_bvalid;
  logic                                axi_s_bready;

  modport slave (
    input  axi_s_araddr, axi_s_arvalid, axi_s_rready,
    input  axi_s_awaddr, axi_s_awvalid, axi_s_wdata, axi_s_wstrb, axi_s_wvalid,
    input  axi_s_bready,
    output axi_s_arready, axi_s_rdata, axi_s_rresp, axi_s_rvalid,
    output axi_s_awready, axi_s_wready, axi_s_bresp, axi_s_bvalid
  );

  modport master (
    output axi_s_araddr, axi_s_arvalid, axi_s_rready,
    output axi_s_awaddr, axi_s_awvalid, axi_s_wdata, axi_s_wstrb, axi_s_wvalid,
    output axi_s_bready,
    input  axi_s_arready, axi_s_rdata, axi_s_rresp, axi_s_rvalid,
    input  axi_s_awready, axi_s_wready, axi_s_bresp, axi_s_bvalid
  );

endinterface

// File: rtl/mips_axi_mem_array.sv
// Byte-writable 2^ADDR_WIDTH x 32 word memory.
// Ports: clk; we/be/waddr/wdata synchronous write; raddr -> rdata_c
// asynchronous read (registered by the parent). Contents are not reset.
module mips_axi_mem_array
  import mips_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AXI_STRB_W-1:0] be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [AXI_DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  // Per-lane write enable.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(AXI_STRB_W); i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/mips_axi_mem_slave.sv
// AXI4-Lite memory slave behind the MIPS CPU master port. One outstanding
// read and one outstanding write; read and write paths are independent.
// Ports: mips_cpu_clk, mips_cpu_reset (async, active-high), axi_s (slave
// modport of mips_axi_mem_slave_if carrying AR/R/AW/W/B).
// Parameters: ADDR_WIDTH word-index bits, RD_LAT AR-to-rvalid cycles (1..15).
// Build option: MIPS_AXI_MEM_DECERR_EN makes addresses with bits above
// ADDR_WIDTH+1 set return DECERR (reads give zero, writes are dropped);
// without it upper address bits alias and every response is OKAY.
module mips_axi_mem_slave
  import mips_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                 mips_cpu_clk,
  input  logic                 mips_cpu_reset,
  mips_axi_mem_slave_if.slave  axi_s
);

  // Read path state.
  rd_state_e             r_state_q, r_state_d;
  logic [RD_CNT_W-1:0]   r_cnt_q, r_cnt_d;
  logic [AXI_ADDR_W-1:0] r_addr_q, r_addr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  // Write path state.
  wr_state_e             w_state_q, w_state_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  wr_req_t               wr_q, wr_d, wr_cur;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs;
  logic                  mem_we;
  logic                  rd_oor, wr_oor;
  logic [AXI_DATA_W-1:0] mem_rdata;

  assign aw_hs = axi_s.axi_s_awvalid & awready_q;
  assign w_hs  = axi_s.axi_s_wvalid  & wready_q;

  // Beat that completes the write may arrive on the commit cycle itself.
  always_comb begin
    wr_cur.addr = aw_got_q ? wr_q.addr : axi_s.axi_s_awaddr;
    wr_cur.data = w_got_q  ? wr_q.data : axi_s.axi_s_wdata;
    wr_cur.strb = w_got_q  ? wr_q.strb : axi_s.axi_s_wstrb;
  end

`ifdef MIPS_AXI_MEM_DECERR_EN
  assign rd_oor = addr_out_of_range(r_addr_q, ADDR_WIDTH);
  assign wr_oor = addr_out_of_range(wr_cur.addr, ADDR_WIDTH);
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
  logic unused_hi_addr;
  assign unused_hi_addr = ^{r_addr_q[AXI_ADDR_W-1:ADDR_WIDTH+2],
                            wr_cur.addr[AXI_ADDR_W-1:ADDR_WIDTH+2]};
`endif

  // Byte offset within a word is ignored.
  logic unused_lo_addr;
  assign unused_lo_addr = ^{r_addr_q[1:0], wr_cur.addr[1:0]};

  mips_axi_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk     (mips_cpu_clk),
    .we      (mem_we),
    .be      (wr_cur.strb),
    .waddr   (wr_cur.addr[ADDR_WIDTH+1:2]),
    .wdata   (wr_cur.data),
    .raddr   (r_addr_q[ADDR_WIDTH+1:2]),
    .rdata_c (mem_rdata)
  );

  // Read FSM registers.
  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read FSM next state; the counter counts down to the edge that registers rdata.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi_s.axi_s_arvalid && arready_q) begin
          r_addr_d  = axi_s.axi_s_araddr;
          r_cnt_d   = RD_CNT_W'(RD_LAT - 1);
          r_state_d = R_WAIT;
          arready_d = 1'b0;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          rdata_d   = rd_oor ? '0 : mem_rdata;
          rresp_d   = rd_oor ? AXI_RESP_DECERR : AXI_RESP_OKAY;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - RD_CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rvalid_q && axi_s.axi_s_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      wr_q      <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      wr_q      <= wr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM next state; commit happens on the edge the second beat lands.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    wr_d      = wr_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          wr_d.addr = axi_s.axi_s_awaddr;
        end
        if (w_hs) begin
          w_got_d   = 1'b1;
          wr_d.data = axi_s.axi_s_wdata;
          wr_d.strb = axi_s.axi_s_wstrb;
        end
        if (aw_got_d && w_got_d) begin
          mem_we    = ~wr_oor;
          bvalid_d  = 1'b1;
          bresp_d   = wr_oor ? AXI_RESP_DECERR : AXI_RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          awready_d = ~aw_got_d;
          wready_d  = ~w_got_d;
        end
      end
      W_RESP: begin
        if (bvalid_q && axi_s.axi_s_bready) begin
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign axi_s.axi_s_arready = arready_q;
  assign axi_s.axi_s_rvalid  = rvalid_q;
  assign axi_s.axi_s_rdata   = rdata_q;
  assign axi_s.axi_s_rresp   = rresp_q;
  assign axi_s.axi_s_awready = awready_q;
  assign axi_s.axi_s_wready  = wready_q;
  assign axi_s.axi_s_bvalid  = bvalid_q;
  assign axi_s.axi_s_bresp   = bresp_q;

endmodule

// File: tb/tb_mips_axi_mem_slave.sv
// Directed bench for mips_axi_mem_slave (ADDR_WIDTH=12, RD_LAT=3).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_mips_axi_mem_slave;
  import mips_axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_axi_mem_slave_if bus();

  mips_axi_mem_slave #(.ADDR_WIDTH(12), .RD_LAT(3)) dut (
    .mips_cpu_clk   (clk),
    .mips_cpu_reset (rst),
    .axi_s          (bus)
  );

`ifdef MIPS_AXI_MEM_DECERR_EN
  localparam logic [31:0] OOR_RESP  = 32'd3;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
  localparam logic [31:0] W0_AFTER  = 32'h1111_2222;
`else
  localparam logic [31:0] OOR_RESP  = 32'd0;
  localparam logic [31:0] OOR_RDATA = 32'h9999_9999;
  localparam logic [31:0] W0_AFTER  = 32'h9999_9999;
`endif

  int total = 0;
  int bad   = 0;

  logic [1:0]  resp;
  logic [31:0] rdat;
  logic [1:0]  rrsp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, 32'(bus.axi_s_arready), 32'd0);
    chk({tag, "_awready"}, 32'(bus.axi_s_awready), 32'd0);
    chk({tag, "_wready"},  32'(bus.axi_s_wready),  32'd0);
    chk({tag, "_rvalid"},  32'(bus.axi_s_rvalid),  32'd0);
    chk({tag, "_bvalid"},  32'(bus.axi_s_bvalid),  32'd0);
    chk({tag, "_rdata"},   bus.axi_s_rdata,        32'd0);
    chk({tag, "_rresp"},   32'(bus.axi_s_rresp),   32'd0);
    chk({tag, "_bresp"},   32'(bus.axi_s_bresp),   32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r);
    logic aw_pend, w_pend, hs_aw, hs_w, done;
    bus.axi_s_awaddr  = a;
    bus.axi_s_awvalid = 1'b1;
    bus.axi_s_wdata   = d;
    bus.axi_s_wstrb   = s;
    bus.axi_s_wvalid  = 1'b1;
    bus.axi_s_bready  = 1'b1;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    done    = 1'b0;
    r       = 2'bxx;
    for (int n = 0; n < 20 && (aw_pend || w_pend); n++) begin
      hs_aw = aw_pend && bus.axi_s_awready;
      hs_w  = w_pend && bus.axi_s_wready;
      @(negedge clk);
      if (hs_aw) begin aw_pend = 1'b0; bus.axi_s_awvalid = 1'b0; end
      if (hs_w)  begin w_pend  = 1'b0; bus.axi_s_wvalid  = 1'b0; end
    end
    bus.axi_s_awvalid = 1'b0;
    bus.axi_s_wvalid  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.axi_s_bvalid) begin
        r    = bus.axi_s_bresp;
        done = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.axi_s_bready = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    logic pend, hs, done;
    bus.axi_s_araddr  = a;
    bus.axi_s_arvalid = 1'b1;
    bus.axi_s_rready  = 1'b1;
    pend = 1'b1;
    done = 1'b0;
    d    = 'x;
    r    = 2'bxx;
    for (int n = 0; n < 20 && pend; n++) begin
      hs = bus.axi_s_arready;
      @(negedge clk);
      if (hs) begin pend = 1'b0; bus.axi_s_arvalid = 1'b0; end
    end
    bus.axi_s_arvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.axi_s_rvalid) begin
        d    = bus.axi_s_rdata;
        r    = bus.axi_s_rresp;
        done = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.axi_s_rready = 1'b0;
    chk("rd_done", 32'(done), 32'd1);
  endtask

  initial begin
    bus.axi_s_araddr  = '0;
    bus.axi_s_arvalid = 1'b0;
    bus.axi_s_rready  = 1'b0;
    bus.axi_s_awaddr  = '0;
    bus.axi_s_awvalid = 1'b0;
    bus.axi_s_wdata   = '0;
    bus.axi_s_wstrb   = '0;
    bus.axi_s_wvalid  = 1'b0;
    bus.axi_s_bready  = 1'b0;

    // Reset values, then readies rise one edge after release.
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rel_arready", 32'(bus.axi_s_arready), 32'd1);
    chk("rel_awready", 32'(bus.axi_s_awready), 32'd1);
    chk("rel_wready",  32'(bus.axi_s_wready),  32'd1);

    // Full-word write then byte-lane-0 merge.
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, resp);
    chk("wr1_bresp", 32'(resp), 32'd0);
    do_write(32'h10, 32'h0000_00AA, 4'b0001, resp);
    chk("wr2_bresp", 32'(resp), 32'd0);
    do_read(32'h10, rdat, rrsp);
    chk("merge_rdata", rdat, 32'hDEAD_BEAA);
    chk("merge_rresp", 32'(rrsp), 32'd0);

    // Read latency of 3 edges, then a 5-cycle rready stall.
    @(negedge clk);
    chk("lat_arready_pre", 32'(bus.axi_s_arready), 32'd1);
    bus.axi_s_araddr  = 32'h10;
    bus.axi_s_arvalid = 1'b1;
    bus.axi_s_rready  = 1'b0;
    @(negedge clk);
    bus.axi_s_arvalid = 1'b0;
    chk("lat_arready_n0", 32'(bus.axi_s_arready), 32'd0);
    chk("lat_rvalid_n0",  32'(bus.axi_s_rvalid),  32'd0);
    @(negedge clk);
    chk("lat_rvalid_n1", 32'(bus.axi_s_rvalid), 32'd0);
    @(negedge clk);
    chk("lat_rvalid_n2", 32'(bus.axi_s_rvalid), 32'd0);
    @(negedge clk);
    chk("lat_rvalid_n3", 32'(bus.axi_s_rvalid), 32'd1);
    chk("lat_rdata_n3",  bus.axi_s_rdata,       32'hDEAD_BEAA);
    bus.axi_s_araddr  = 32'h30;
    bus.axi_s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid",  32'(bus.axi_s_rvalid),  32'd1);
      chk("stall_rdata",   bus.axi_s_rdata,        32'hDEAD_BEAA);
      chk("stall_arready", 32'(bus.axi_s_arready), 32'd0);
    end
    bus.axi_s_arvalid = 1'b0;
    bus.axi_s_rready  = 1'b1;
    @(negedge clk);
    bus.axi_s_rready = 1'b0;
    chk("rhs_rvalid", 32'(bus.axi_s_rvalid), 32'd0);
    @(negedge clk);
    chk("rhs_arready", 32'(bus.axi_s_arready), 32'd1);

    // AW two cycles ahead of W, B held off by bready=0.
    chk("aww_awready_pre", 32'(bus.axi_s_awready), 32'd1);
    bus.axi_s_awaddr  = 32'h30;
    bus.axi_s_awvalid = 1'b1;
    bus.axi_s_bready  = 1'b0;
    @(negedge clk);
    bus.axi_s_awvalid = 1'b0;
    chk("aw0_awready", 32'(bus.axi_s_awready), 32'd0);
    chk("aw0_wready",  32'(bus.axi_s_wready),  32'd1);
    chk("aw0_bvalid",  32'(bus.axi_s_bvalid),  32'd0);
    @(negedge clk);
    chk("aw1_awready", 32'(bus.axi_s_awready), 32'd0);
    chk("aw1_wready",  32'(bus.axi_s_wready),  32'd1);
    chk("aw1_bvalid",  32'(bus.axi_s_bvalid),  32'd0);
    bus.axi_s_wdata  = 32'h1234_5678;
    bus.axi_s_wstrb  = 4'hF;
    bus.axi_s_wvalid = 1'b1;
    @(negedge clk);
    bus.axi_s_wvalid = 1'b0;
    chk("w_bvalid",  32'(bus.axi_s_bvalid),  32'd1);
    chk("w_bresp",   32'(bus.axi_s_bresp),   32'd0);
    chk("w_wready",  32'(bus.axi_s_wready),  32'd0);
    chk("w_awready", 32'(bus.axi_s_awready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bhold_bvalid",  32'(bus.axi_s_bvalid),  32'd1);
      chk("bhold_awready", 32'(bus.axi_s_awready), 32'd0);
    end
    bus.axi_s_bready = 1'b1;
    @(negedge clk);
    bus.axi_s_bready = 1'b0;
    chk("bhs_bvalid", 32'(bus.axi_s_bvalid), 32'd0);
    @(negedge clk);
    chk("bhs_awready", 32'(bus.axi_s_awready), 32'd1);
    chk("bhs_wready",  32'(bus.axi_s_wready),  32'd1);
    do_read(32'h30, rdat, rrsp);
    chk("aww_rdata", rdat, 32'h1234_5678);

    // Address above the word-index field.
    do_write(32'h0, 32'h1111_2222, 4'hF, resp);
    chk("w0_bresp", 32'(resp), 32'd0);
    do_write(32'h0001_0000, 32'h9999_9999, 4'hF, resp);
    chk("oor_bresp", 32'(resp), OOR_RESP);
    do_read(32'h0001_0000, rdat, rrsp);
    chk("oor_rdata", rdat, OOR_RDATA);
    chk("oor_rresp", 32'(rrsp), OOR_RESP);
    do_read(32'h0, rdat, rrsp);
    chk("w0_rdata", rdat, W0_AFTER);
    chk("w0_rresp", 32'(rrsp), 32'd0);

    // Reset during R_WAIT with only AW captured.
    do_write(32'h40, 32'hCAFE_0040, 4'hF, resp);
    @(negedge clk);
    bus.axi_s_araddr  = 32'h40;
    bus.axi_s_arvalid = 1'b1;
    bus.axi_s_awaddr  = 32'h40;
    bus.axi_s_awvalid = 1'b1;
    @(negedge clk);
    bus.axi_s_arvalid = 1'b0;
    bus.axi_s_awvalid = 1'b0;
    chk("abort_arready", 32'(bus.axi_s_arready), 32'd0);
    chk("abort_awready", 32'(bus.axi_s_awready), 32'd0);
    chk("abort_wready",  32'(bus.axi_s_wready),  32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_arready", 32'(bus.axi_s_arready), 32'd1);
    chk("post_awready", 32'(bus.axi_s_awready), 32'd1);
    chk("post_wready",  32'(bus.axi_s_wready),  32'd1);
    do_write(32'h50, 32'h5555_5555, 4'hF, resp);
    do_read(32'h40, rdat, rrsp);
    chk("post_rdata40", rdat, 32'hCAFE_0040);
    do_read(32'h50, rdat, rrsp);
    chk("post_rdata50", rdat, 32'h5555_5555);

    // Write commits on the same edge that registers rdata.
    do_write(32'h20, 32'hAAAA_0020, 4'hF, resp);
    @(negedge clk);
    bus.axi_s_araddr  = 32'h20;
    bus.axi_s_arvalid = 1'b1;
    bus.axi_s_rready  = 1'b0;
    @(negedge clk);
    bus.axi_s_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.axi_s_awaddr  = 32'h20;
    bus.axi_s_wdata   = 32'hBBBB_0020;
    bus.axi_s_wstrb   = 4'hF;
    bus.axi_s_awvalid = 1'b1;
    bus.axi_s_wvalid  = 1'b1;
    bus.axi_s_bready  = 1'b0;
    @(negedge clk);
    bus.axi_s_awvalid = 1'b0;
    bus.axi_s_wvalid  = 1'b0;
    chk("coll_rvalid", 32'(bus.axi_s_rvalid), 32'd1);
    chk("coll_rdata",  bus.axi_s_rdata,       32'hAAAA_0020);
    chk("coll_bvalid", 32'(bus.axi_s_bvalid), 32'd1);
    bus.axi_s_rready = 1'b1;
    bus.axi_s_bready = 1'b1;
    @(negedge clk);
    bus.axi_s_rready = 1'b0;
    bus.axi_s_bready = 1'b0;
    chk("coll_rvalid_done", 32'(bus.axi_s_rvalid), 32'd0);
    chk("coll_bvalid_done", 32'(bus.axi_s_bvalid), 32'd0);
    @(negedge clk);
    do_read(32'h20, rdat, rrsp);
    chk("coll_rdata2", rdat, 32'hBBBB_0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
